// File: rtl/priority_pkg.sv
// Shared types and helpers for the priority encoder/decoder pair.
package priority_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int DEF_CODE_W = 3;
  localparam int DEF_OUT_W  = 8;

  // Widest code/one-hot the helper handles; callers truncate to their own width.
  localparam int CODE_MAX   = 8;
  localparam int ONEHOT_MAX = 256;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [CODE_MAX-1:0] code);
    logic [ONEHOT_MAX-1:0] one_s;
    one_s = {{(ONEHOT_MAX-1){1'b0}}, 1'b1};
    return one_s << code;
  endfunction

endpackage

// File: rtl/priority_decoder_pend.sv
// One-entry holding register for a code that arrives while a grant is still being held.
module code_pend_reg
  import priority_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              clr,
  input  logic [CODE_W-1:0] wr_code,
  output logic              full,
  output logic [CODE_W-1:0] code
);

  logic              full_r;
  logic [CODE_W-1:0] code_r;

  // Pending entry: write wins over clear (the two never coincide in use).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_r <= 1'b0;
      code_r <= '0;
    end else if (wr) begin
      full_r <= 1'b1;
      code_r <= wr_code;
    end else if (clr) begin
      full_r <= 1'b0;
      code_r <= code_r;
    end else begin
      full_r <= full_r;
      code_r <= code_r;
    end
  end

  assign full = full_r;
  assign code = code_r;

endmodule

// File: rtl/priority_decoder.sv
// Registered code-to-one-hot grant driver: each accepted code is held for HOLD cycles,
// with a one-entry pending buffer so consecutive grants need no idle gap.
module priority_decoder
  import priority_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int HOLD   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [OUT_W-1:0]  out_onehot,
  output logic              out_valid,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD - 1);

  state_e             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
  logic [OUT_W-1:0]   onehot_r, onehot_nxt_s;
  logic               valid_r, done_r, err_r;
  logic               accept_s, in_range_s;
  logic               pend_full_s, pend_wr_s, pend_clr_s;
  logic [CODE_W-1:0]  pend_code_s;
  logic               load_s;
  logic [CODE_W-1:0]  load_code_s;

  code_pend_reg #(.CODE_W(CODE_W)) u_pend (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (pend_wr_s),
    .clr     (pend_clr_s),
    .wr_code (in_code),
    .full    (pend_full_s),
    .code    (pend_code_s)
  );

  assign in_ready   = rst_n & ~pend_full_s;
  assign accept_s   = in_valid & in_ready;
  assign in_range_s = ({1'b0, in_code} < (CODE_W + 1)'(OUT_W));

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      onehot_r <= '0;
      valid_r  <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      onehot_r <= onehot_nxt_s;
      valid_r  <= (state_nxt_s == ACTIVE);
      done_r   <= (state_nxt_s == ACTIVE) && (cnt_nxt_s == '0);
      err_r    <= accept_s & ~in_range_s;
    end
  end

  // Next-state selection: pending code beats a same-edge bypass at the end of a hold.
  always_comb begin
    load_s      = 1'b0;
    load_code_s = in_code;
    pend_wr_s   = 1'b0;
    pend_clr_s  = 1'b0;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s && in_range_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ACTIVE: begin
        if (cnt_r != '0) begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
          pend_wr_s = accept_s & in_range_s;
        end else if (pend_full_s) begin
          load_s      = 1'b1;
          load_code_s = pend_code_s;
          pend_clr_s  = 1'b1;
        end else if (accept_s && in_range_s) begin
          load_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    if (load_s) begin
      state_nxt_s = ACTIVE;
      cnt_nxt_s   = CNT_LOAD;
    end else begin
      cnt_nxt_s = cnt_nxt_s;
    end
  end

  // One-hot for the next cycle; cleared whenever the block returns to IDLE.
  always_comb begin
    onehot_nxt_s = onehot_r;
    if (load_s) begin
      onehot_nxt_s = OUT_W'(onehot(CODE_MAX'(load_code_s)));
    end else if (state_nxt_s == IDLE) begin
      onehot_nxt_s = '0;
    end else begin
      onehot_nxt_s = onehot_r;
    end
  end

  assign out_onehot = onehot_r;
  assign out_valid  = valid_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule

// File: doc/priority_decoder.md
Name: priority_decoder

Overview:
Registered 3-to-8 decoder that is the counterpart of priority_encoder. It accepts a binary code over a valid/ready handshake and drives the matching one-hot line for a programmable number of cycles. A one-entry pending buffer allows back-to-back codes with no idle gap. It sits at the grant side of an arbiter: the encoder picks a winner code, and this block turns that code back into a timed one-hot grant.

Parameters:
CODE_W, 3, width of the input code
OUT_W, 8, number of one-hot output lines; must satisfy OUT_W <= 2**CODE_W
HOLD, 4, cycles each one-hot value is held; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  in_code is valid
in_ready  output  1  block can accept a code
in_code  input  CODE_W  binary code to decode
out_onehot  output  OUT_W  registered one-hot grant; all-zero when idle
out_valid  output  1  out_onehot is meaningful
done  output  1  one-cycle pulse during the last held cycle of each code
err  output  1  one-cycle pulse when an out-of-range code is accepted

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active-low. All state updates happen on the rising edge of clk.
- Reset values while rst_n=0 and on the first cycle after release: out_onehot=0, out_valid=0, done=0, err=0, pending empty, state IDLE.
- in_ready is forced to 0 while rst_n=0. Otherwise in_ready = !pend_full (combinational from registers only, never from in_valid).
- Accept: a transfer happens at a rising edge when in_valid && in_ready. The block never stalls the output side.
- Range check: an accepted code >= OUT_W is dropped. err=1 for exactly the next cycle. No state change and no pending write.
- States:
  - IDLE: on accept, go to ACTIVE next cycle with out_onehot = 1<<code, out_valid=1, cnt=HOLD-1. Latency is 1 cycle from the accept edge.
  - ACTIVE: cnt decrements each cycle. done=1 combinationally while cnt==0.
    - Accept while cnt!=0: the code is written to pending; pend_full=1 next cycle.
    - At the edge ending a cnt==0 cycle, the next action is chosen in this priority order:
      1. pend_full: load the pending code, stay ACTIVE, cnt=HOLD-1, clear pending.
      2. Else, accept that same edge: load the input code directly (bypass), stay ACTIVE.
      3. Else: go to IDLE with out_onehot=0 and out_valid=0.
- If pending is full and in cnt==0, in_ready=0, so no simultaneous write occurs.
- Consequences:
  - HOLD=1 streams one code per cycle with pending never filling.
  - For HOLD>1 the grant is gap-free between consecutive codes.
- Reset mid-operation: a synchronous reset overrides everything. The pending code is discarded and never appears on out_onehot.
- Counter width: $clog2(HOLD) with a minimum of 1. Decrement only in ACTIVE; no wrap is possible.
- out_onehot always has 0 or 1 bits set. It is nonzero iff out_valid=1.

Decomposition:
- Shared package (priority_pkg):
  - state enum {IDLE, ACTIVE}
  - default CODE_W=3 and OUT_W=8, shared with priority_encoder
  - function onehot(code) returning 1<<code
- Sub-module code_pend_reg: one-entry register holding {pend_full, pend_code}, with write, clear and sync-reset inputs.
- Decode, counter and FSM stay in the top level. Estimated 150–200 lines total.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with in_valid=1 and in_code=5 -> in_ready=0, all outputs 0, nothing is output after release.
2. Single code: code=2 accepted at edge T0, HOLD=4 -> out_onehot=8'b00000100 with out_valid=1 for T1..T4, done=1 only in T4, out_onehot=0 from T5.
3. Back-to-back: codes 0, 7, 3 offered on consecutive cycles, in_valid held, HOLD=4 -> 8'h01 for 4 cycles then 8'h80 for 4 cycles with no gap. in_ready=0 while pending is full, and code 3 is accepted only after 8'h80 loads.
4. Range error with OUT_W=6: code=6 -> err pulse for 1 cycle, out_onehot stays 0. Then code=5 -> out_onehot=6'b100000.
5. Reset mid-operation: rst_n=0 in the 2nd active cycle of code 1 with code 4 pending -> the next cycle is all zero and in_ready=1 after release. 8'h10 never appears.
6. HOLD=1 streaming: codes 1, 2, 3 offered on consecutive cycles -> out_onehot = 8'h02, 8'h04, 8'h08 on consecutive cycles, done=1 each cycle, in_ready stays 1.
